// File: rtl/maxpool_2x2.sv
// maxpool_2x2: streaming 2x2, stride-2 max-pooling stage for a raster-order
// pixel stream. Output width and height are the input dimensions halved
// (floor). One half-row buffer holds the pair maxima of each even row until
// the following odd row completes the window.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   inValid      inputPixel accepted on this edge when high
//   inputPixel   input pixel, WORD_SIZE bits unsigned
//   outValid     one-cycle pulse, outputPixel carries a new pooled value
//   outputPixel  pooled pixel, holds while outValid is low
//   frameDone    one-cycle pulse after the last pixel of a frame is accepted
module maxpool_2x2 #(
  parameter int unsigned WORD_SIZE    = 8,
  parameter int unsigned ROW_SIZE     = 540,
  parameter int unsigned IMAGE_HEIGHT = 360
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  input  logic [WORD_SIZE-1:0] inputPixel,
  output logic                 outValid,
  output logic [WORD_SIZE-1:0] outputPixel,
  output logic                 frameDone
);

  localparam int unsigned COL_W     = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int unsigned ROW_W     = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned BUF_DEPTH = (ROW_SIZE / 2 > 0) ? ROW_SIZE / 2 : 1;
  localparam int unsigned BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [WORD_SIZE-1:0] h_q, h_d;
  logic                 out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0] out_pixel_q, out_pixel_d;
  logic                 frame_done_q, frame_done_d;

  // Pair maxima of the most recent even row, indexed by col>>1.
  logic [WORD_SIZE-1:0] row_buf_q [BUF_DEPTH];

  logic [BUF_AW-1:0]    buf_idx_c;
  logic [WORD_SIZE-1:0] buf_rdata_c;
  logic                 buf_we_c;
  logic [WORD_SIZE-1:0] pair_max_c;
  logic                 last_col_c;
  logic                 last_row_c;

  assign buf_idx_c   = BUF_AW'(col_q >> 1);
  assign buf_rdata_c = row_buf_q[buf_idx_c];
  assign pair_max_c  = (inputPixel > h_q) ? inputPixel : h_q;
  assign last_col_c  = (col_q == COL_W'(ROW_SIZE - 1));
  assign last_row_c  = (row_q == ROW_W'(IMAGE_HEIGHT - 1));

  // Next-state: pair/window reduction and raster counters, advanced only on accepted pixels.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    h_d          = h_q;
    out_valid_d  = 1'b0;
    out_pixel_d  = out_pixel_q;
    frame_done_d = 1'b0;
    buf_we_c     = 1'b0;

    if (inValid) begin
      // Even column opens a pair; odd column closes it. A trailing even
      // column of an odd-width row only lands in h and is overwritten later.
      if (!col_q[0]) begin
        h_d = inputPixel;
      end else if (!row_q[0]) begin
        buf_we_c = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_pixel_d = (pair_max_c > buf_rdata_c) ? pair_max_c : buf_rdata_c;
      end

      if (last_col_c) begin
        col_d = '0;
        if (last_row_c) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      h_q          <= '0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      h_q          <= h_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Row buffer carries no reset: each entry is written on an even row before its odd-row read.
  always_ff @(posedge clk) begin
    if (buf_we_c && !rst) begin
      row_buf_q[buf_idx_c] <= pair_max_c;
    end
  end

  assign outValid    = out_valid_q;
  assign outputPixel = out_pixel_q;
  assign frameDone   = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
// Directed bench for maxpool_2x2: a 4x4 instance for most scenarios and a
// 5x3 instance for odd dimensions. Inputs change on the falling edge and
// outputs are sampled on the falling edge following the accepting edge.
module tb_maxpool_2x2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, in_valid4, out_valid4, frame_done4;
  logic [7:0] in_pix4, out_pix4;
  logic       rst53, in_valid53, out_valid53, frame_done53;
  logic [7:0] in_pix53, out_pix53;

  int n_checks = 0;
  int n_fail   = 0;

  maxpool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(4), .IMAGE_HEIGHT(4)) dut4 (
    .clk(clk), .rst(rst4), .inValid(in_valid4), .inputPixel(in_pix4),
    .outValid(out_valid4), .outputPixel(out_pix4), .frameDone(frame_done4)
  );

  maxpool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(5), .IMAGE_HEIGHT(3)) dut53 (
    .clk(clk), .rst(rst53), .inValid(in_valid53), .inputPixel(in_pix53),
    .outValid(out_valid53), .outputPixel(out_pix53), .frameDone(frame_done53)
  );

  // One clock on the 4x4 instance; returns at the next falling edge.
  task automatic step4(input logic v, input logic [7:0] px);
    in_valid4 = v;
    in_pix4   = px;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step53(input logic v, input logic [7:0] px);
    in_valid53 = v;
    in_pix53   = px;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst53 = 1'b1;
    in_valid53 = 1'b1; in_pix53 = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step4(1'b1, 8'hAA);
      n_checks++;
      if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_outValid cyc=%0d got=%b exp=0", i, out_valid4); end
      n_checks++;
      if (out_pix4 !== 8'h00) begin n_fail++; $display("FAIL reset_outputPixel cyc=%0d got=%h exp=00", i, out_pix4); end
      n_checks++;
      if (frame_done4 !== 1'b0) begin n_fail++; $display("FAIL reset_frameDone cyc=%0d got=%b exp=0", i, frame_done4); end
      n_checks++;
      if (out_valid53 !== 1'b0 || out_pix53 !== 8'h00 || frame_done53 !== 1'b0) begin
        n_fail++; $display("FAIL reset_dut53 cyc=%0d got v=%b p=%h f=%b exp 0/00/0", i, out_valid53, out_pix53, frame_done53);
      end
    end
    rst4 = 1'b0; rst53 = 1'b0;
    in_valid53 = 1'b0;
    step4(1'b0, 8'h00);
    n_checks++;
    if (out_valid4 !== 1'b0 || out_pix4 !== 8'h00) begin
      n_fail++; $display("FAIL reset_release got v=%b p=%h exp 0/00", out_valid4, out_pix4);
    end
  endtask

  // Full 4x4 ramp at one pixel per cycle; outputs expected after pixels 5, 7, 13, 15.
  task automatic test_ramp(input string tag);
    logic exp_v;
    int   n_out;
    n_out = 0;
    for (int i = 0; i < 16; i++) begin
      exp_v = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      step4(1'b1, 8'(i));
      n_checks++;
      if (out_valid4 !== exp_v) begin n_fail++; $display("FAIL %s_outValid pix=%0d got=%b exp=%b", tag, i, out_valid4, exp_v); end
      if (out_valid4 === 1'b1) n_out++;
      if (exp_v) begin
        n_checks++;
        if (out_pix4 !== 8'(i)) begin n_fail++; $display("FAIL %s_value pix=%0d got=%h exp=%h", tag, i, out_pix4, 8'(i)); end
      end
      n_checks++;
      if (frame_done4 !== (i == 15)) begin n_fail++; $display("FAIL %s_frameDone pix=%0d got=%b exp=%b", tag, i, frame_done4, (i == 15)); end
    end
    n_checks++;
    if (n_out != 4) begin n_fail++; $display("FAIL %s_count got=%0d exp=4", tag, n_out); end
    step4(1'b0, 8'h00);
    n_checks++;
    if (out_valid4 !== 1'b0 || out_pix4 !== 8'h0F || frame_done4 !== 1'b0) begin
      n_fail++; $display("FAIL %s_hold got v=%b p=%h f=%b exp 0/0f/0", tag, out_valid4, out_pix4, frame_done4);
    end
  endtask

  task automatic test_max_position();
    logic [7:0] frm [16];
    logic [7:0] exp_out [4];
    int         k;
    for (int i = 0; i < 16; i++) frm[i] = 8'h00;
    frm[0]  = 8'hFF;   // (0,0)
    frm[7]  = 8'h80;   // (1,3)
    frm[9]  = 8'h7F;   // (2,1)
    frm[15] = 8'h81;   // (3,3)
    exp_out[0] = 8'hFF; exp_out[1] = 8'h80; exp_out[2] = 8'h7F; exp_out[3] = 8'h81;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      step4(1'b1, frm[i]);
      if (out_valid4 === 1'b1) begin
        n_checks++;
        if (k >= 4 || out_pix4 !== exp_out[k & 3]) begin
          n_fail++; $display("FAIL maxpos_value idx=%0d got=%h exp=%h", k, out_pix4, exp_out[k & 3]);
        end
        k++;
      end
    end
    n_checks++;
    if (k != 4) begin n_fail++; $display("FAIL maxpos_count got=%0d exp=4", k); end
  endtask

  task automatic test_bubbles();
    logic [7:0] exp_out [4];
    int         k;
    int         n_fd;
    exp_out[0] = 8'h05; exp_out[1] = 8'h07; exp_out[2] = 8'h0D; exp_out[3] = 8'h0F;
    k = 0; n_fd = 0;
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < 2; s++) begin
        step4(s == 0, 8'(i));
        if (out_valid4 === 1'b1) begin
          n_checks++;
          if (k >= 4 || out_pix4 !== exp_out[k & 3]) begin
            n_fail++; $display("FAIL bubbles_value idx=%0d got=%h exp=%h", k, out_pix4, exp_out[k & 3]);
          end
          k++;
        end
        if (frame_done4 === 1'b1) n_fd++;
      end
      if (i == 1) begin
        for (int g = 0; g < 5; g++) begin
          step4(1'b0, 8'h5A);
          if (out_valid4 === 1'b1) k++;
        end
      end
    end
    n_checks++;
    if (k != 4) begin n_fail++; $display("FAIL bubbles_count got=%0d exp=4", k); end
    n_checks++;
    if (n_fd != 1) begin n_fail++; $display("FAIL bubbles_frameDone got=%0d exp=1", n_fd); end
  endtask

  // Partial frame, one reset cycle (with inValid high), then a complete ramp.
  task automatic test_mid_frame_reset();
    for (int i = 0; i < 6; i++) step4(1'b1, 8'(i));
    n_checks++;
    if (out_valid4 !== 1'b1 || out_pix4 !== 8'h05) begin
      n_fail++; $display("FAIL midrst_partial got v=%b p=%h exp 1/05", out_valid4, out_pix4);
    end
    rst4 = 1'b1;
    step4(1'b1, 8'h33);
    rst4 = 1'b0;
    n_checks++;
    if (out_valid4 !== 1'b0 || out_pix4 !== 8'h00 || frame_done4 !== 1'b0) begin
      n_fail++; $display("FAIL midrst_reset got v=%b p=%h f=%b exp 0/00/0", out_valid4, out_pix4, frame_done4);
    end
    test_ramp("midrst");
  endtask

  // 5x3: only windows (rows 0-1, cols 0-1) and (rows 0-1, cols 2-3) produce output.
  task automatic test_odd_dims();
    logic exp_v;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 15; i++) begin
        exp_v = (i == 6) || (i == 8);
        step53(1'b1, 8'(i));
        n_checks++;
        if (out_valid53 !== exp_v) begin n_fail++; $display("FAIL odd_outValid frame=%0d pix=%0d got=%b exp=%b", f, i, out_valid53, exp_v); end
        if (exp_v) begin
          n_checks++;
          if (out_pix53 !== 8'(i)) begin n_fail++; $display("FAIL odd_value frame=%0d pix=%0d got=%h exp=%h", f, i, out_pix53, 8'(i)); end
        end
        n_checks++;
        if (frame_done53 !== (i == 14)) begin n_fail++; $display("FAIL odd_frameDone frame=%0d pix=%0d got=%b exp=%b", f, i, frame_done53, (i == 14)); end
      end
    end
    step53(1'b0, 8'h00);
  endtask

  initial begin
    rst4 = 1'b1; in_valid4 = 1'b0; in_pix4 = 8'h00;
    rst53 = 1'b1; in_valid53 = 1'b0; in_pix53 = 8'h00;
    @(negedge clk);
    test_reset();
    test_ramp("ramp");
    test_max_position();
    test_bubbles();
    test_mid_frame_reset();
    test_odd_dims();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool_2x2.md
# maxpool_2x2

Streaming 2x2, stride-2 max-pooling stage that sits directly downstream of the `convolution` block. It consumes the convolution output as a raster-order pixel stream and emits one pooled pixel per 2x2 window, also in raster order. Width and height are halved, using floor division. Internal storage is a half-row buffer, so full-frame storage is not required.

## Interface
Parameters:
- `WORD_SIZE`, 8: pixel width in bits, unsigned.
- `ROW_SIZE`, 540: input pixels per row.
- `IMAGE_HEIGHT`, 360: input rows per frame.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inValid`  in  1  `inputPixel` is accepted on a rising edge where `inValid`=1.
- `inputPixel`  in  `WORD_SIZE`  convolution output pixel.
- `outValid`  out  1  one-cycle pulse; `outputPixel` carries a new pooled value.
- `outputPixel`  out  `WORD_SIZE`  pooled pixel; holds its last value while `outValid`=0.
- `frameDone`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Counters:
  - `col` runs 0..`ROW_SIZE`-1; `row` runs 0..`IMAGE_HEIGHT`-1.
  - Both advance only on accepted pixels.
  - `col` wraps to 0 and increments `row`; `row` wraps to 0 at end of frame.
- Pixel pair handling:
  - Even `col`: the pixel is stored in the hold register `h`.
  - Odd `col`: `p` = max(`h`, pixel).
- Even `row`, odd `col`: `p` is written to row buffer entry `col>>1`. The buffer has `ROW_SIZE`/2 entries of `WORD_SIZE` bits.
- Odd `row`, odd `col`:
  - `outputPixel` <= max(`p`, buffer[`col>>1`]).
  - `outValid` <= 1.
- All comparisons are unsigned, with no width growth. On ties, any of the equal values may be selected, since the result is identical.
- Odd `ROW_SIZE`: the last column is accepted and counted but never pooled (floor).
- Odd `IMAGE_HEIGHT`: the last row is accepted and counted but produces no output.
- `frameDone` <= 1 on the edge that accepts pixel (`IMAGE_HEIGHT`-1, `ROW_SIZE`-1). The next accepted pixel is (0,0) of a new frame.
- `inValid` bubbles of any length are allowed anywhere, including mid-pair and across row boundaries. State is held during bubbles.
- There is no backpressure; downstream must accept every `outValid` pulse.

## Timing
- Reset values, applied on the edge where `rst`=1:
  - `outValid`=0, `outputPixel`=0, `frameDone`=0.
  - `col`=0, `row`=0, `h`=0.
  - `rst` overrides `inValid`.
  - Buffer contents are not reset. Every entry is written on an even row before it is read on the following odd row.
- Reset mid-frame: the partial frame is discarded with no further output from it. The first accepted pixel after `rst` is deasserted is (0,0).
- Latency: `outValid`/`outputPixel` update on the same edge that accepts the odd-row, odd-col pixel. They are visible in the following cycle, one register stage.
- Output rate: at most one `outValid` per 2 accepted pixels. There are exactly floor(`ROW_SIZE`/2)·floor(`IMAGE_HEIGHT`/2) pulses per frame.
- Same-edge events: on the last pixel of a frame with even dimensions, `outValid` and `frameDone` assert together.
- Throughput: one pixel per cycle sustained, with no stall cycles at row or frame wrap.

## Test plan
All scenarios use `WORD_SIZE`=8 unless stated.
- Reset: `rst`=1 for 3 cycles with `inValid`=1 and `inputPixel`=0xAA. Required: `outValid`=0, `outputPixel`=0x00 and `frameDone`=0 throughout, and no output is produced from those pixels.
- Ramp, `ROW_SIZE`=4, `IMAGE_HEIGHT`=4: feed pixels 0x00..0x0F at one per cycle. Required:
  - outputs 0x05, 0x07, 0x0D, 0x0F, in order;
  - each one cycle after pixels 5, 7, 13 and 15 respectively;
  - `frameDone` is a single pulse coincident with the 0x0F output.
- Max position and unsigned compare, 4x4: the frame is all 0x00 except (0,0)=0xFF, (1,3)=0x80, (2,1)=0x7F, (3,3)=0x81. Required outputs: 0xFF, 0x80, 0x7F, 0x81.
- Bubbles: repeat the 4x4 ramp with `inValid` alternating 1,0, plus a 5-cycle gap between pixel 1 and pixel 2. Required: identical output values and order to the ramp scenario, and exactly 4 `outValid` pulses.
- Odd dimensions, `ROW_SIZE`=5, `IMAGE_HEIGHT`=3: feed ramp 0x00..0x0E. Required:
  - only outputs 0x06 and 0x08;
  - one `frameDone` after pixel 0x0E;
  - a following second frame ramp yields 0x06 and 0x08 again.
- Reset mid-frame, 4x4: feed 6 ramp pixels, assert `rst` for 1 cycle, then a full 0x00..0x0F ramp. Required: exactly 4 outputs, 0x05, 0x07, 0x0D and 0x0F, with no output before the new frame's pixel 5.
